// File: rtl/adder_pg_stage.sv
// adder_pg_stage: operand capture and generate/propagate precompute.
// Build option: ADDER_PG_SKID_EN adds a two-entry skid with registered in_ready.
module adder_pg_stage #(
  parameter int LEN_DATA = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LEN_DATA-1:0] op_a,
  input  logic [LEN_DATA-1:0] op_b,
  input  logic                op_sub,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] generate_out,
  output logic [LEN_DATA-1:0] propogate_out,
  output logic [LEN_DATA-1:0] half_sum_out,
  output logic                cin_out
);

  typedef struct packed {
    logic [LEN_DATA-1:0] gen;
    logic [LEN_DATA-1:0] prop;
    logic [LEN_DATA-1:0] half;
    logic                cin;
  } pg_t;

  logic [LEN_DATA-1:0] b_eff;
  logic [LEN_DATA-1:0] g_raw;
  logic [LEN_DATA-1:0] p_raw;
  logic                c_eff;
  pg_t                 pg_d;
  pg_t                 main_q;
  logic                xfer_in;
  logic                xfer_out;

  // Invert B for subtract and fold the carry-in into bit 0.
  always_comb begin
    b_eff        = op_sub ? ~op_b : op_b;
    c_eff        = cin ^ op_sub;
    g_raw        = op_a & b_eff;
    p_raw        = op_a ^ b_eff;
    pg_d.gen     = g_raw;
    pg_d.gen[0]  = g_raw[0] | (p_raw[0] & c_eff);
    pg_d.prop    = p_raw;
    pg_d.prop[0] = 1'b0;
    pg_d.half    = p_raw;
    pg_d.cin     = c_eff;
  end

`ifdef ADDER_PG_SKID_EN

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } state_t;

  state_t state_q;
  state_t state_d;
  pg_t    skid_q;
  logic   rdy_q;
  logic   load_main;
  logic   load_skid;
  logic   pop_skid;

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign xfer_in   = in_valid & rdy_q;
  assign xfer_out  = out_valid & out_ready;

  // Occupancy state and the registered ready derived from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  // Next occupancy and which register loads this cycle.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        unique case (1'b1)
          xfer_in & ~xfer_out: begin
            state_d   = FULL;
            load_skid = 1'b1;
          end
          xfer_in & xfer_out: begin
            load_main = 1'b1;
          end
          ~xfer_in & xfer_out: begin
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (xfer_out) begin
          state_d  = BUSY;
          pop_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Main and skid data registers; skid drains into main.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= pg_d;
      end else if (pop_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= pg_d;
      end
    end
  end

`else

  logic valid_q;

  assign out_valid = valid_q;
  assign in_ready  = ~valid_q | out_ready;
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = valid_q & out_ready;

  // Single output register; a new beat replaces a draining one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (xfer_in) begin
      valid_q <= 1'b1;
      main_q  <= pg_d;
    end else if (xfer_out) begin
      valid_q <= 1'b0;
    end
  end

`endif

  assign generate_out  = main_q.gen;
  assign propogate_out = main_q.prop;
  assign half_sum_out  = main_q.half;
  assign cin_out       = main_q.cin;

endmodule

// File: tb/tb_adder_pg_stage.sv
// tb_adder_pg_stage: directed checks of the PG precompute stage.
// Works for both the base and ADDER_PG_SKID_EN builds.
module tb_adder_pg_stage;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] generate_out;
  logic [W-1:0] propogate_out;
  logic [W-1:0] half_sum_out;
  logic         cin_out;

  int   checks = 0;
  int   errors = 0;
  logic acc;
  int   b_taken;

  logic [W-1:0] sa [16];
  logic [W-1:0] sb [16];
  logic         ss [16];
  logic         sc [16];

  always #5 clk = ~clk;

  adder_pg_stage #(.LEN_DATA(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_sub       (op_sub),
    .cin          (cin),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .generate_out (generate_out),
    .propogate_out(propogate_out),
    .half_sum_out (half_sum_out),
    .cin_out      (cin_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] g,
                         input logic [W-1:0] p, input logic [W-1:0] h,
                         input logic c);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".gen"}, {24'd0, generate_out}, {24'd0, g});
    chk({tag, ".prop"}, {24'd0, propogate_out}, {24'd0, p});
    chk({tag, ".half"}, {24'd0, half_sum_out}, {24'd0, h});
    chk({tag, ".cin"}, {31'd0, cin_out}, {31'd0, c});
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c);
    op_a   = a;
    op_b   = b;
    op_sub = s;
    cin    = c;
  endtask

  task automatic tick();
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic ref_pg(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c,
                        output logic [W-1:0] g, output logic [W-1:0] p,
                        output logic [W-1:0] h, output logic co);
    logic [W-1:0] bb;
    bb   = s ? ~b : b;
    co   = c ^ s;
    h    = a ^ bb;
    g    = a & bb;
    g[0] = g[0] | (h[0] & co);
    p    = h;
    p[0] = 1'b0;
  endtask

  function automatic logic [W-1:0] sum_of(input logic [W-1:0] g,
                                          input logic [W-1:0] p,
                                          input logic [W-1:0] h,
                                          input logic c);
    logic [W-1:0] s;
    logic         cy;
    s[0] = h[0] ^ c;
    cy   = g[0];
    for (int i = 1; i < W; i++) begin
      s[i] = h[i] ^ cy;
      cy   = g[i] | (p[i] & cy);
    end
    return s;
  endfunction

  initial begin
    logic [W-1:0] eg, ep, eh, bb, es;
    logic         ec;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.gen", {24'd0, generate_out}, 32'd0);
    chk("rst.prop", {24'd0, propogate_out}, 32'd0);
    chk("rst.half", {24'd0, half_sum_out}, 32'd0);
    chk("rst.cin", {31'd0, cin_out}, 32'd0);
    chk("rst.ready", {31'd0, in_ready}, 32'd1);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // add
    in_valid = 1'b1;
    drive(8'h0F, 8'h01, 1'b0, 1'b0);
    tick();
    chk("add.acc", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    chk_out("add", 8'h01, 8'h0E, 8'h0E, 1'b0);
    tick();
    chk("add.drain", {31'd0, out_valid}, 32'd0);

    // subtract
    in_valid = 1'b1;
    drive(8'h05, 8'h03, 1'b1, 1'b0);
    tick();
    chk("sub.acc", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    chk_out("sub", 8'h05, 8'hF8, 8'hF9, 1'b1);
    chk("sub.sum",
        {24'd0, sum_of(generate_out, propogate_out, half_sum_out, cin_out)},
        32'h02);
    tick();

    // carry-in fold
    in_valid = 1'b1;
    drive(8'h01, 8'h00, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("fold", 8'h01, 8'h00, 8'h01, 1'b1);
    tick();

    // backpressure: A accepted, B waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(8'h0F, 8'h01, 1'b0, 1'b0);
    tick();
    chk("bp.accA", {31'd0, acc}, 32'd1);
    drive(8'h05, 8'h03, 1'b1, 1'b0);
    b_taken = 0;
    chk_out("bp.first", 8'h01, 8'h0E, 8'h0E, 1'b0);
`ifdef ADDER_PG_SKID_EN
    chk("bp.ready0", {31'd0, in_ready}, 32'd1);
`else
    chk("bp.ready0", {31'd0, in_ready}, 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      if (acc) begin
        b_taken++;
        in_valid = 1'b0;
      end
      chk_out("bp.hold", 8'h01, 8'h0E, 8'h0E, 1'b0);
      chk("bp.ready", {31'd0, in_ready}, 32'd0);
    end
`ifdef ADDER_PG_SKID_EN
    chk("bp.skidB", b_taken, 32'd1);
`else
    chk("bp.noB", b_taken, 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    if (acc) begin
      b_taken++;
      in_valid = 1'b0;
    end
    chk_out("bp.B", 8'h05, 8'hF8, 8'hF9, 1'b1);
    tick();
    chk("bp.end", {31'd0, out_valid}, 32'd0);
    chk("bp.onceB", b_taken, 32'd1);

    // streaming
    for (int i = 0; i < 16; i++) begin
      sa[i] = W'($urandom_range(0, 255));
      sb[i] = W'($urandom_range(0, 255));
      ss[i] = 1'($urandom_range(0, 1));
      sc[i] = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(sa[i], sb[i], ss[i], sc[i]);
      tick();
      chk("st.acc", {31'd0, acc}, 32'd1);
      ref_pg(sa[i], sb[i], ss[i], sc[i], eg, ep, eh, ec);
      chk_out("st", eg, ep, eh, ec);
      bb = ss[i] ? ~sb[i] : sb[i];
      es = sa[i] + bb + {7'd0, ss[i] ^ sc[i]};
      chk("st.sum",
          {24'd0, sum_of(generate_out, propogate_out, half_sum_out, cin_out)},
          {24'd0, es});
    end
    in_valid = 1'b0;
    tick();
    chk("st.end", {31'd0, out_valid}, 32'd0);

    // async reset mid-stream
    in_valid = 1'b1;
    drive(8'h33, 8'h11, 1'b0, 1'b0);
    tick();
    drive(8'h44, 8'h22, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("ar.valid", {31'd0, out_valid}, 32'd0);
    chk("ar.gen", {24'd0, generate_out}, 32'd0);
    chk("ar.ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ar.noout", {31'd0, out_valid}, 32'd0);
    chk("ar.ready2", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    drive(8'h01, 8'h00, 1'b0, 1'b1);
    tick();
    chk("ar.acc", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    chk_out("ar.new", 8'h01, 8'h00, 8'h01, 1'b1);
    tick();
    chk("ar.end", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder_pg_stage.md
# adder_pg_stage

Operand-capture and generate/propagate precompute stage of the pipelined parallel-prefix adder. Registers `op_a`/`op_b` behind a valid/ready handshake and applies subtract inversion and carry-in folding. Emits per-bit generate/propagate vectors consumed directly by the first prefix stage (`adder_stage1`), plus the half-sum and effective carry-in needed by the final sum stage. One transaction per cycle at full throughput.

## Interface
- `LEN_DATA`, from `main.def.v` (32): operand width; all vectors are `LEN_DATA` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  stage accepts a beat this cycle.
- `op_a`  in  LEN_DATA  operand A.
- `op_b`  in  LEN_DATA  operand B.
- `op_sub`  in  1  1 = compute A − B.
- `cin`  in  1  carry-in; borrow-in when `op_sub`=1.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream prefix stage accepts.
- `generate_out`  out  LEN_DATA  folded generate vector.
- `propogate_out`  out  LEN_DATA  folded propagate vector.
- `half_sum_out`  out  LEN_DATA  raw `a ^ b'` for the final sum XOR.
- `cin_out`  out  1  effective carry-in.

## Operation
- Preprocess: `b' = op_sub ? ~op_b : op_b`; `c = cin ^ op_sub`.
- Raw vectors: `g = op_a & b'`; `p = op_a ^ b'`.
- Carry-in fold at bit 0: `generate_out[0] = g[0] | (p[0] & c)`; `propogate_out[0] = 0`. Bits 1..LEN_DATA−1 pass `g`/`p` unchanged.
- `half_sum_out = p` (unfolded); `cin_out = c`.
- Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`.
- Output data changes only on a transfer-out or on a load into an empty output register; it holds stable while `out_valid & !out_ready`.
- Computation happens before the register; outputs are driven straight from flops.

## Timing
- Reset (async assert, sync deassert at next edge): `out_valid`=0, all data outputs 0, `cin_out`=0. `in_ready` is 1 out of reset.
- Latency: 1 cycle from transfer-in to `out_valid`.
- Base mode: `in_ready = !out_valid | out_ready` (combinational from `out_ready`). Register loads on transfer-in; `out_valid` clears on a transfer-out with no simultaneous transfer-in.
- Simultaneous transfer-in and transfer-out: the new beat replaces the old one and `out_valid` stays 1. No bubble occurs.
- `in_valid` with `in_ready`=0: no state change. Upstream holds operands.
- `rst` mid-transaction: the in-flight beat is discarded. No output is produced for it.

## Configuration
- `ADDER_PG_SKID_EN` defined: a two-entry skid buffer makes `in_ready` a flop with no combinational path from `out_ready`.
  - States: EMPTY (`out_valid`=0), BUSY (main reg valid), FULL (main + skid valid).
  - EMPTY→BUSY on transfer-in.
  - BUSY→FULL on transfer-in without transfer-out.
  - BUSY→EMPTY on transfer-out without transfer-in.
  - FULL→BUSY on transfer-out; skid moves to main.
  - `in_ready` = (state != FULL), registered. Reset: EMPTY, `in_ready`=1.
- Undefined: base mode as above. Ports and latency are identical in both builds.

## Test plan
- LEN_DATA=8. Add, `a=0x0F, b=0x01, sub=0, cin=0` → `generate_out=0x01, propogate_out=0x0E, half_sum_out=0x0E, cin_out=0`, one cycle after accept.
- Subtract, `a=0x05, b=0x03, sub=1, cin=0` → `generate_out=0x05, propogate_out=0xF8, half_sum_out=0xF9, cin_out=1`; downstream sum must be 0x02.
- Carry-in fold, `a=0x01, b=0x00, sub=0, cin=1` → `generate_out=0x01, propogate_out=0x00, half_sum_out=0x01, cin_out=1`.
- Backpressure: `out_ready` held 0 for 3 cycles with `in_valid` asserted.
  - Output held stable.
  - Base build: `in_ready`=0 once `out_valid`=1.
  - Skid build: second beat accepted, then `in_ready`=0.
  - After release, beats emerge in order with no loss or duplication.
- Streaming: 16 random beats with `in_valid`=`out_ready`=1 continuously → 16 outputs on consecutive cycles, each matching the reference model.
- Async reset asserted mid-stream between clock edges → `out_valid` drops immediately; after release, `in_ready`=1 and the first new beat emerges 1 cycle after accept.
